// File: rtl/axis_pkg.sv
// Shared constants, state encoding and round-robin helper for the AXI-Stream merge path.
package axis_pkg;

  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned ID_WIDTH  = 2;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t IDLE = 1'b0;
  localparam arb_state_t PASS = 1'b1;

  // Returns {found, idx}: first requester in the order last+1, last+2, last+3 (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    idx = last;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!res[2] && req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep valid/ready output register carrying data, keep, last and source id.
module axis_reg_slice #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEEP_WIDTH = 4,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [KEEP_WIDTH-1:0] in_keep,
  input  logic                  in_last,
  input  logic [ID_WIDTH-1:0]   in_id,
  output logic                  in_ready_c,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [KEEP_WIDTH-1:0] out_keep,
  output logic                  out_last,
  output logic [ID_WIDTH-1:0]   out_id,
  input  logic                  out_ready
);

  // Register may accept a new beat when empty or when its current beat leaves this cycle.
  assign in_ready_c = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
    end else if (in_valid && in_ready_c) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_last  <= in_last;
      out_id    <= in_id;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_arbiter_merge.sv
// Three-to-one AXI-Stream merge with packet-atomic round-robin arbitration and a
// registered output tagged with the source port.
module axis_arbiter_merge
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEEP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
  input  logic                  s_axis_tvalid_0,
  output logic                  s_axis_tready_0,
  input  logic                  s_axis_tlast_0,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  output logic                  s_axis_tready_1,
  input  logic                  s_axis_tlast_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  output logic                  s_axis_tready_2,
  input  logic                  s_axis_tlast_2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid
);

  arb_state_t            state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0]  req_c;
  logic [NUM_PORTS-1:0]  ready_c;
  logic [2:0]            pick_c;
  logic                  load_en_c;
  logic                  hs_c;
  logic                  sel_valid_c;
  logic [DATA_WIDTH-1:0] sel_data_c;
  logic [KEEP_WIDTH-1:0] sel_keep_c;
  logic                  sel_last_c;

  assign req_c = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};

  // Input mux driven by the held grant.
  always_comb begin
    sel_valid_c = 1'b0;
    sel_data_c  = '0;
    sel_keep_c  = '0;
    sel_last_c  = 1'b0;
    case (grant_q)
      2'd0: begin
        sel_valid_c = s_axis_tvalid_0;
        sel_data_c  = s_axis_tdata_0;
        sel_keep_c  = s_axis_tkeep_0;
        sel_last_c  = s_axis_tlast_0;
      end
      2'd1: begin
        sel_valid_c = s_axis_tvalid_1;
        sel_data_c  = s_axis_tdata_1;
        sel_keep_c  = s_axis_tkeep_1;
        sel_last_c  = s_axis_tlast_1;
      end
      2'd2: begin
        sel_valid_c = s_axis_tvalid_2;
        sel_data_c  = s_axis_tdata_2;
        sel_keep_c  = s_axis_tkeep_2;
        sel_last_c  = s_axis_tlast_2;
      end
      default: ;
    endcase
  end

  // Arbitration FSM: grant is locked from the first beat until the tlast beat is accepted.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ready_c      = '0;
    hs_c         = 1'b0;
    pick_c       = rr_pick(req_c, last_grant_q);
    case (state_q)
      IDLE: begin
        if (pick_c[2]) begin
          grant_d = pick_c[1:0];
          state_d = PASS;
        end
      end
      PASS: begin
        ready_c = NUM_PORTS'(load_en_c) << grant_q;
        hs_c    = sel_valid_c && load_en_c;
        if (hs_c && sel_last_c) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= 2'd2;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign s_axis_tready_0 = ready_c[0];
  assign s_axis_tready_1 = ready_c[1];
  assign s_axis_tready_2 = ready_c[2];

  axis_reg_slice #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .ID_WIDTH   (ID_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (hs_c),
    .in_data    (sel_data_c),
    .in_keep    (sel_keep_c),
    .in_last    (sel_last_c),
    .in_id      (grant_q),
    .in_ready_c (load_en_c),
    .out_valid  (m_axis_tvalid),
    .out_data   (m_axis_tdata),
    .out_keep   (m_axis_tkeep),
    .out_last   (m_axis_tlast),
    .out_id     (m_axis_tid),
    .out_ready  (m_axis_tready)
  );

endmodule

// File: tb/tb_axis_arbiter_merge.sv
// Bench for axis_arbiter_merge: directed steps plus randomized traffic against a
// packet-level round-robin scoreboard.
module tb_axis_arbiter_merge;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata [3];
  logic [3:0]  s_tkeep [3];
  logic [2:0]  s_tvalid = '0;
  logic [2:0]  s_tlast  = '0;
  logic [2:0]  s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [1:0]  m_tid;

  axis_arbiter_merge #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata_0  (s_tdata[0]),
    .s_axis_tkeep_0  (s_tkeep[0]),
    .s_axis_tvalid_0 (s_tvalid[0]),
    .s_axis_tready_0 (s_tready[0]),
    .s_axis_tlast_0  (s_tlast[0]),
    .s_axis_tdata_1  (s_tdata[1]),
    .s_axis_tkeep_1  (s_tkeep[1]),
    .s_axis_tvalid_1 (s_tvalid[1]),
    .s_axis_tready_1 (s_tready[1]),
    .s_axis_tlast_1  (s_tlast[1]),
    .s_axis_tdata_2  (s_tdata[2]),
    .s_axis_tkeep_2  (s_tkeep[2]),
    .s_axis_tvalid_2 (s_tvalid[2]),
    .s_axis_tready_2 (s_tready[2]),
    .s_axis_tlast_2  (s_tlast[2]),
    .m_axis_tdata    (m_tdata),
    .m_axis_tkeep    (m_tkeep),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tready   (m_tready),
    .m_axis_tlast    (m_tlast),
    .m_axis_tid      (m_tid)
  );

  always #5 clk = ~clk;

  beat_t       src_q [3][$];
  beat_t       exp_q [3][$];
  int          out_tids[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mid_pkt [3];
  bit          held [3];
  int          acc_cnt [3];
  bit          stall_en = 1'b0;
  int          ready_mode = 0;
  int          cur_src = -1;
  int          last_src = 2;
  int          last_end_cyc = -1;
  int          prev_beat_cyc = 0;
  bit          timing_chk = 1'b0;
  int          start_cyc = 0;
  int          first_cyc = -1;
  bit          prev_stall = 1'b0;
  logic [38:0] prev_payload = '0;
  bit          chk_lock = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    beat_t b;
    for (int p = 0; p < 3; p++) begin
      if (src_q[p].size() == 0) begin
        s_tvalid[p] = 1'b0;
        s_tdata[p]  = '0;
        s_tkeep[p]  = '0;
        s_tlast[p]  = 1'b0;
      end else begin
        b = src_q[p][0];
        s_tvalid[p] = held[p] || !(stall_en && mid_pkt[p] && $urandom_range(0, 2) == 0);
        s_tdata[p]  = b.data;
        s_tkeep[p]  = b.keep;
        s_tlast[p]  = b.last;
      end
    end
  endtask

  task automatic load_pkt(input int p, input int len, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = base + 32'(i);
      b.keep = 4'($urandom_range(1, 15));
      b.last = (i == len - 1);
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  // Scoreboard: a new packet must come from the next non-empty port after the last winner.
  task automatic check_out();
    beat_t got, want;
    int    exp_src, p;
    got = {m_tdata, m_tkeep, m_tlast};
    if (cur_src < 0) begin
      exp_src = -1;
      for (int k = 1; k <= 3; k++) begin
        p = (last_src + k) % 3;
        if (exp_src < 0 && exp_q[p].size() > 0) exp_src = p;
      end
      chk("pkt_expected", 64'(exp_src >= 0), 64'd1);
      if (exp_src < 0) return;
      if (timing_chk && last_end_cyc >= 0) chk("bubble", 64'(cyc - last_end_cyc), 64'd2);
      if (first_cyc < 0) first_cyc = cyc;
      cur_src = exp_src;
    end else if (timing_chk) begin
      chk("beat_gap", 64'(cyc - prev_beat_cyc), 64'd1);
    end
    prev_beat_cyc = cyc;
    out_tids.push_back(int'(m_tid));
    chk("tid", 64'(m_tid), 64'(cur_src));
    want = exp_q[cur_src].pop_front();
    chk("payload", 64'(got), 64'(want));
    if (want.last) begin
      last_src     = cur_src;
      cur_src      = -1;
      last_end_cyc = cyc;
    end
  endtask

  task automatic tick();
    logic [2:0] hs;
    beat_t      b;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    if (!rst) begin
      if (prev_stall)
        chk("stall_stable", 64'({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid}), 64'({1'b1, prev_payload}));
      prev_stall   = m_tvalid && !m_tready;
      prev_payload = {m_tdata, m_tkeep, m_tlast, m_tid};
      if (chk_lock && acc_cnt[0] < 4) chk("lock_ready1", 64'(s_tready[1]), 64'd0);
      if (m_tvalid && m_tready) check_out();
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 3; p++) begin
      held[p] = s_tvalid[p] && !hs[p];
      if (hs[p] === 1'b1 && src_q[p].size() > 0) begin
        b = src_q[p].pop_front();
        acc_cnt[p]++;
        mid_pkt[p] = !b.last;
      end
    end
    case (ready_mode)
      1:       m_tready = !m_tready;
      2:       m_tready = ($urandom_range(0, 3) != 0);
      default: m_tready = 1'b1;
    endcase
    drive_src();
  endtask

  task automatic drain(input int limit);
    bit done;
    done = 1'b0;
    for (int n = 0; n < limit; n++) begin
      done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && (src_q[2].size() == 0) &&
             (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0) &&
             (cur_src < 0) && (m_tvalid === 1'b0);
      if (done) break;
      tick();
    end
    chk("drain_done", 64'(done), 64'd1);
  endtask

  initial begin
    int exp_seq[8];
    int n;
    exp_seq = '{0, 0, 1, 1, 2, 2, 0, 0};

    // Reset with every input requesting; afterwards port 0 wins first.
    load_pkt(0, 2, 32'h100);
    load_pkt(1, 2, 32'h110);
    load_pkt(2, 2, 32'h120);
    drive_src();
    repeat (3) begin
      tick();
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_m_tdata", 64'(m_tdata), 64'd0);
      chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
      chk("rst_m_tlast", 64'(m_tlast), 64'd0);
      chk("rst_m_tid", 64'(m_tid), 64'd0);
      chk("rst_s_tready", 64'(s_tready), 64'd0);
    end
    rst = 1'b0;
    out_tids.delete();
    drain(200);
    chk("post_rst_order", 64'(out_tids[0]), 64'd0);

    // All ports busy back to back: fixed rotation, full rate inside, one bubble between.
    timing_chk   = 1'b1;
    last_end_cyc = -1;
    out_tids.delete();
    load_pkt(0, 2, 32'h200);
    load_pkt(0, 2, 32'h210);
    load_pkt(1, 2, 32'h220);
    load_pkt(2, 2, 32'h230);
    drive_src();
    drain(200);
    timing_chk = 1'b0;
    chk("seq_len", 64'(out_tids.size()), 64'd8);
    for (int i = 0; i < 8 && i < out_tids.size(); i++) chk("tid_seq", 64'(out_tids[i]), 64'(exp_seq[i]));

    // Single 4-beat packet on port 1 and its first-beat latency.
    first_cyc = -1;
    load_pkt(1, 4, 32'hA0);
    drive_src();
    start_cyc = cyc;
    drain(200);
    chk("first_latency", 64'(first_cyc - start_cyc), 64'd2);

    // Downstream ready toggling every cycle during a 5-beat packet on port 2.
    ready_mode = 1;
    load_pkt(2, 5, 32'hC0);
    drive_src();
    drain(300);
    ready_mode = 0;
    m_tready   = 1'b1;

    // Port 1 requests while port 0 is mid-packet; it must wait for port 0's tlast.
    for (int p = 0; p < 3; p++) acc_cnt[p] = 0;
    chk_lock = 1'b1;
    out_tids.delete();
    load_pkt(0, 4, 32'hD0);
    drive_src();
    n = 0;
    while (acc_cnt[0] < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("wait_beat2", 64'(acc_cnt[0] >= 2), 64'd1);
    load_pkt(1, 2, 32'hE0);
    drive_src();
    drain(200);
    chk_lock = 1'b0;
    chk("lock_order", 64'(out_tids.size() == 6 ? out_tids[4] : -1), 64'd1);

    // Reset after the first beat of a 3-beat packet; priority returns to port 0.
    for (int p = 0; p < 3; p++) acc_cnt[p] = 0;
    load_pkt(0, 3, 32'hF0);
    drive_src();
    n = 0;
    while (acc_cnt[0] < 1 && n < 50) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      mid_pkt[p] = 1'b0;
      held[p]    = 1'b0;
    end
    cur_src    = -1;
    last_src   = 2;
    prev_stall = 1'b0;
    drive_src();
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd0);
    out_tids.delete();
    load_pkt(2, 1, 32'h300);
    load_pkt(0, 1, 32'h310);
    drive_src();
    drain(200);
    chk("midrst_first_port", 64'(out_tids.size() > 0 ? out_tids[0] : -1), 64'd0);

    // Randomized traffic with downstream backpressure and mid-packet source gaps.
    ready_mode = 2;
    stall_en   = 1'b1;
    repeat (8) begin
      for (int p = 0; p < 3; p++) begin
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) load_pkt(p, $urandom_range(1, 5), $urandom);
      end
      drive_src();
      drain(3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
